sysctrl_gen: RTL and testbench

Parametrised MCU system-control slave for all cores. It decodes the byte-serial command stream from the MCU SPI front end and exposes a generic indexed config-variable file with per-variable write strobes. It also provides a parametrised interrupt aggregator, a buffered MCU→core port FIFO with valid/ready handshake, and LED/colour/button service. It replaces per-core hard-coded config decoding; cores map `cfg_vars` slices to their own settings.

---
 rtl/sysctrl_gen.sv | 253 +++++++++++++++++++++++++
 tb/tb_sysctrl_gen.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysctrl_gen.sv
// MCU system-control slave: byte-serial command decoder, indexed config-variable file,
// interrupt aggregator, MCU-to-core port FIFO and LED/colour/button service.
module sysctrl_gen #(
    parameter logic [7:0]  CORE_ID      = 8'h01,
    parameter int unsigned NUM_VARS     = 16,
    parameter logic [7:0]  VAR_BASE     = 8'h41,
    parameter int unsigned INT_CHANNELS = 8,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    data_in_strobe,
    input  logic                    data_in_start,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    output logic                    int_out_n,
    input  logic [INT_CHANNELS-1:0] int_in,
    output logic [INT_CHANNELS-1:0] int_ack,
    input  logic [1:0]              buttons,
    output logic [1:0]              leds,
    output logic [23:0]             color,
    output logic [8*NUM_VARS-1:0]   cfg_vars,
    output logic [NUM_VARS-1:0]     cfg_strobe,
    input  logic                    port_out_available,
    input  logic [7:0]              port_out_data,
    output logic                    port_out_strobe,
    output logic [7:0]              port_in_data,
    output logic                    port_in_valid,
    input  logic                    port_in_ready
);
    localparam int unsigned PTR_W = 9;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;

    // Pointer value that can never reach a valid variable again
    localparam logic [PTR_W-1:0] PTR_DEAD = '1;

    localparam logic [7:0] CMD_STATUS  = 8'd0;
    localparam logic [7:0] CMD_LEDS    = 8'd1;
    localparam logic [7:0] CMD_COLOR   = 8'd2;
    localparam logic [7:0] CMD_BUTTONS = 8'd3;
    localparam logic [7:0] CMD_VAR_WR  = 8'd4;
    localparam logic [7:0] CMD_INT     = 8'd5;
    localparam logic [7:0] CMD_SYSSTAT = 8'd6;
    localparam logic [7:0] CMD_PORTOUT = 8'd7;
    localparam logic [7:0] CMD_PORTIN  = 8'd8;
    localparam logic [7:0] CMD_VAR_RD  = 8'd9;
    localparam logic [7:0] CMD_FIFOST  = 8'd10;

    logic [7:0]           command_q, command_d;
    logic [7:0]           idx_q, idx_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d, ptr_new, var_ptr, ptr_next;
    logic [7:0]           latch_q, latch_d;
    logic [7:0]           var_rdata, data_rev;
    logic                 overflow_q, overflow_d;
    logic                 coldboot_q, coldboot_d;
    logic                 sys_int_q, sys_int_d;
    logic                 poa_q;

    logic [7:0]           data_out_d;
    logic [1:0]           leds_d;
    logic [23:0]          color_d;
    logic [8*NUM_VARS-1:0] cfg_vars_d;
    logic [NUM_VARS-1:0]  cfg_strobe_d;
    logic [INT_CHANNELS-1:0] int_ack_d;
    logic                 port_out_strobe_d;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        count_q, count_d;
    logic [7:0]           head_d;
    logic                 valid_d;
    logic                 push_req, push_ok, pop, drop, clr_overflow, fifo_full;
    logic                 unused_int0;

    assign unused_int0 = int_in[0];
    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign int_out_n   = ~((|int_in[INT_CHANNELS-1:1]) | sys_int_q);

    // Variable pointer handling shared by burst write and burst read
    always_comb begin
        ptr_new  = (data_in < VAR_BASE) ? PTR_DEAD : {1'b0, data_in - VAR_BASE};
        var_ptr  = (idx_q == 8'd1) ? ptr_new : ptr_q;
        ptr_next = (var_ptr == PTR_DEAD) ? var_ptr : var_ptr + PTR_W'(1);
        var_rdata = 8'h00;
        for (int i = 0; i < int'(NUM_VARS); i++) begin
            if (var_ptr == PTR_W'(i)) var_rdata = cfg_vars[8*i +: 8];
        end
        for (int i = 0; i < 8; i++) data_rev[i] = data_in[7-i];
    end

    // Command decoder: next state and reply for each strobed byte
    always_comb begin
        command_d         = command_q;
        idx_d             = idx_q;
        ptr_d             = ptr_q;
        latch_d           = latch_q;
        coldboot_d        = coldboot_q;
        data_out_d        = data_out;
        leds_d            = leds;
        color_d           = color;
        cfg_vars_d        = cfg_vars;
        cfg_strobe_d      = '0;
        int_ack_d         = '0;
        port_out_strobe_d = 1'b0;
        push_req          = 1'b0;
        clr_overflow      = 1'b0;

        if (data_in_strobe && data_in_start) begin
            command_d = data_in;
            idx_d     = 8'd1;
        end else if (data_in_strobe && idx_q != 8'd0) begin
            idx_d = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;
            case (command_q)
                CMD_STATUS: begin
                    case (idx_q)
                        8'd1:    data_out_d = 8'h5C;
                        8'd2:    data_out_d = 8'h42;
                        8'd3:    data_out_d = CORE_ID;
                        8'd4:    data_out_d = 8'(NUM_VARS);
                        default: ;
                    endcase
                end
                CMD_LEDS: begin
                    if (idx_q == 8'd1) leds_d = data_in[1:0];
                end
                CMD_COLOR: begin
                    case (idx_q)
                        8'd1:    color_d[15:8]  = data_rev;
                        8'd2:    color_d[7:0]   = data_rev;
                        8'd3:    color_d[23:16] = data_rev;
                        default: ;
                    endcase
                end
                CMD_BUTTONS: data_out_d = {6'b0, buttons};
                CMD_VAR_WR: begin
                    if (idx_q == 8'd1) begin
                        ptr_d = ptr_new;
                    end else begin
                        for (int i = 0; i < int'(NUM_VARS); i++) begin
                            if (var_ptr == PTR_W'(i)) begin
                                cfg_vars_d[8*i +: 8] = data_in;
                                cfg_strobe_d[i]      = 1'b1;
                            end
                        end
                        ptr_d = ptr_next;
                    end
                end
                CMD_INT: begin
                    if (idx_q == 8'd1) int_ack_d = data_in[INT_CHANNELS-1:0];
                    data_out_d = 8'({int_in[INT_CHANNELS-1:1], sys_int_q});
                end
                CMD_SYSSTAT: begin
                    data_out_d = {4'b0, overflow_q, fifo_full, port_out_available, coldboot_q};
                    if (idx_q == 8'd1) coldboot_d = 1'b0;
                end
                CMD_PORTOUT: begin
                    if (idx_q == 8'd1) begin
                        data_out_d        = {7'b0, port_out_available};
                        latch_d           = port_out_data;
                        port_out_strobe_d = port_out_available;
                    end else if (idx_q == 8'd2) begin
                        data_out_d = latch_q;
                    end
                end
                CMD_PORTIN: push_req = 1'b1;
                CMD_VAR_RD: begin
                    data_out_d = var_rdata;
                    ptr_d      = ptr_next;
                end
                CMD_FIFOST: begin
                    if (idx_q == 8'd1) data_out_d = 8'(CW'(FIFO_DEPTH) - count_q);
                    else if (idx_q == 8'd2) clr_overflow = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // FIFO bookkeeping, sticky overflow and system interrupt
    always_comb begin
        pop     = port_in_valid & port_in_ready;
        push_ok = push_req & (~fifo_full | pop);
        drop    = push_req & fifo_full & ~pop;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Registered head: bypass the byte being written if it lands at the new head
        head_d  = (push_ok && wr_q == rd_d) ? data_in : mem[rd_d];
        valid_d = (count_d != CW'(0));

        overflow_d = overflow_q;
        if (drop) overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;

        sys_int_d = (port_out_available & ~poa_q) | (drop & ~overflow_q) | (sys_int_q & ~int_ack[0]);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            command_q       <= 8'd0;
            idx_q           <= 8'd0;
            ptr_q           <= '0;
            latch_q         <= 8'd0;
            overflow_q      <= 1'b0;
            coldboot_q      <= 1'b1;
            sys_int_q       <= 1'b1;
            poa_q           <= 1'b0;
            data_out        <= 8'd0;
            leds            <= 2'd0;
            color           <= 24'd0;
            cfg_vars        <= '0;
            cfg_strobe      <= '0;
            int_ack         <= '0;
            port_out_strobe <= 1'b0;
            wr_q            <= '0;
            rd_q            <= '0;
            count_q         <= '0;
            port_in_data    <= 8'd0;
            port_in_valid   <= 1'b0;
        end else begin
            command_q       <= command_d;
            idx_q           <= idx_d;
            ptr_q           <= ptr_d;
            latch_q         <= latch_d;
            overflow_q      <= overflow_d;
            coldboot_q      <= coldboot_d;
            sys_int_q       <= sys_int_d;
            poa_q           <= port_out_available;
            data_out        <= data_out_d;
            leds            <= leds_d;
            color           <= color_d;
            cfg_vars        <= cfg_vars_d;
            cfg_strobe      <= cfg_strobe_d;
            int_ack         <= int_ack_d;
            port_out_strobe <= port_out_strobe_d;
            wr_q            <= wr_d;
            rd_q            <= rd_d;
            count_q         <= count_d;
            port_in_data    <= head_d;
            port_in_valid   <= valid_d;
        end
    end

endmodule

// File: tb/tb_sysctrl_gen.sv
// Self-checking bench for sysctrl_gen: directed scenarios plus random frames,
// compared every cycle against a queue/array model of the command rules.
module tb_sysctrl_gen;
    localparam int         NV    = 16;
    localparam logic [7:0] BASE  = 8'h41;
    localparam int         ICH   = 8;
    localparam int         DEPTH = 8;
    localparam logic [7:0] CORE  = 8'h01;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              data_in_strobe, data_in_start;
    logic [7:0]        data_in, data_out;
    logic              int_out_n;
    logic [ICH-1:0]    int_in, int_ack;
    logic [1:0]        buttons, leds;
    logic [23:0]       color;
    logic [8*NV-1:0]   cfg_vars;
    logic [NV-1:0]     cfg_strobe;
    logic              port_out_available, port_out_strobe;
    logic [7:0]        port_out_data, port_in_data;
    logic              port_in_valid, port_in_ready;

    int checks = 0;
    int failures = 0;

    sysctrl_gen #(.CORE_ID(CORE), .NUM_VARS(NV), .VAR_BASE(BASE),
                  .INT_CHANNELS(ICH), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .data_in_strobe(data_in_strobe), .data_in_start(data_in_start),
        .data_in(data_in), .data_out(data_out), .int_out_n(int_out_n),
        .int_in(int_in), .int_ack(int_ack), .buttons(buttons), .leds(leds),
        .color(color), .cfg_vars(cfg_vars), .cfg_strobe(cfg_strobe),
        .port_out_available(port_out_available), .port_out_data(port_out_data),
        .port_out_strobe(port_out_strobe), .port_in_data(port_in_data),
        .port_in_valid(port_in_valid), .port_in_ready(port_in_ready)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int         m_cmd, m_idx, m_ptr;
    logic [7:0] m_vars [NV];
    logic [NV-1:0] m_strobe;
    logic [7:0] m_ack, m_dout, m_latch;
    logic       m_pos, m_ovf, m_cold, m_sys, m_poa_prev;
    logic [1:0] m_leds;
    logic [23:0] m_color;
    logic [7:0] m_fifo [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic int id_to_ptr(input logic [7:0] id);
        return (id < BASE) ? 100000 : int'(id) - int'(BASE);
    endfunction

    task automatic model_reset();
        m_cmd = 0; m_idx = 0; m_ptr = 0;
        for (int i = 0; i < NV; i++) m_vars[i] = 8'h00;
        m_strobe = '0; m_ack = '0; m_dout = 8'h00; m_latch = 8'h00;
        m_pos = 1'b0; m_ovf = 1'b0; m_cold = 1'b1; m_sys = 1'b1; m_poa_prev = 1'b0;
        m_leds = 2'b00; m_color = 24'h0;
        m_fifo.delete();
    endtask

    // Next-cycle expectations from the inputs that the coming edge will sample
    task automatic model_step();
        logic pop, push, drop, clr, prev_ack0;
        int k;
        logic [7:0] din;
        din = data_in;
        prev_ack0 = m_ack[0];
        pop = (m_fifo.size() > 0) && port_in_ready;
        push = 1'b0; drop = 1'b0; clr = 1'b0;
        m_strobe = '0; m_ack = '0; m_pos = 1'b0;
        if (data_in_strobe && data_in_start) begin
            m_cmd = int'(din);
            m_idx = 1;
        end else if (data_in_strobe && m_idx != 0) begin
            k = m_idx;
            case (m_cmd)
                0: begin
                    if (k == 1) m_dout = 8'h5C;
                    else if (k == 2) m_dout = 8'h42;
                    else if (k == 3) m_dout = CORE;
                    else if (k == 4) m_dout = 8'(NV);
                end
                1: if (k == 1) m_leds = din[1:0];
                2: begin
                    if (k == 1) m_color[15:8] = rev8(din);
                    else if (k == 2) m_color[7:0] = rev8(din);
                    else if (k == 3) m_color[23:16] = rev8(din);
                end
                3: m_dout = {6'b0, buttons};
                4: begin
                    if (k == 1) m_ptr = id_to_ptr(din);
                    else begin
                        if (m_ptr >= 0 && m_ptr < NV) begin
                            m_vars[m_ptr] = din;
                            m_strobe[m_ptr] = 1'b1;
                        end
                        m_ptr++;
                    end
                end
                5: begin
                    if (k == 1) m_ack = din;
                    m_dout = {int_in[ICH-1:1], m_sys};
                end
                6: begin
                    m_dout = {4'b0, m_ovf, (m_fifo.size() == DEPTH), port_out_available, m_cold};
                    if (k == 1) m_cold = 1'b0;
                end
                7: begin
                    if (k == 1) begin
                        m_dout = {7'b0, port_out_available};
                        m_latch = port_out_data;
                        m_pos = port_out_available;
                    end else if (k == 2) m_dout = m_latch;
                end
                8: push = 1'b1;
                9: begin
                    if (k == 1) m_ptr = id_to_ptr(din);
                    m_dout = (m_ptr >= 0 && m_ptr < NV) ? m_vars[m_ptr] : 8'h00;
                    m_ptr++;
                end
                10: begin
                    if (k == 1) m_dout = 8'(DEPTH - m_fifo.size());
                    else if (k == 2) clr = 1'b1;
                end
                default: ;
            endcase
            if (m_idx < 255) m_idx++;
        end
        if (push && m_fifo.size() >= DEPTH && !pop) drop = 1'b1;
        if (pop) void'(m_fifo.pop_front());
        if (push && !drop) m_fifo.push_back(din);
        m_sys = (port_out_available && !m_poa_prev) || (drop && !m_ovf) || (m_sys && !prev_ack0);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_poa_prev = port_out_available;
    endtask

    task automatic compare_all();
        logic [127:0] ev;
        ev = '0;
        for (int i = 0; i < NV; i++) ev[8*i +: 8] = m_vars[i];
        check("data_out", 128'(data_out), 128'(m_dout));
        check("leds", 128'(leds), 128'(m_leds));
        check("color", 128'(color), 128'(m_color));
        check("cfg_vars", 128'(cfg_vars), ev);
        check("cfg_strobe", 128'(cfg_strobe), 128'(m_strobe));
        check("int_ack", 128'(int_ack), 128'(m_ack));
        check("port_out_strobe", 128'(port_out_strobe), 128'(m_pos));
        check("port_in_valid", 128'(port_in_valid), 128'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) check("port_in_data", 128'(port_in_data), 128'(m_fifo[0]));
        check("int_out_n", 128'(int_out_n), 128'(!((int_in[ICH-1:1] != 7'd0) || m_sys)));
    endtask

    task automatic tick();
        if (!reset_n) model_reset();
        else model_step();
        @(posedge clk);
        #2;
        compare_all();
        @(negedge clk);
    endtask

    task automatic send(input logic start, input logic [7:0] d);
        data_in_strobe = 1'b1;
        data_in_start  = start;
        data_in        = d;
        tick();
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
    endtask

    task automatic randomize_bg();
        port_in_ready = 1'($urandom_range(0, 1));
        buttons       = 2'($urandom);
        port_out_data = 8'($urandom);
        if ($urandom_range(0, 15) == 0) port_out_available = ~port_out_available;
        int_in = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
    endtask

    initial begin
        int got;
        int c, len;
        logic [7:0] d;
        reset_n = 1'b0; data_in_strobe = 1'b0; data_in_start = 1'b0; data_in = 8'h00;
        int_in = '0; buttons = 2'b00; port_out_available = 1'b0; port_out_data = 8'h00;
        port_in_ready = 1'b0;
        model_reset();
        @(negedge clk);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("rst_int_out_n", 128'(int_out_n), 128'(1'b0));
        check("rst_data_out", 128'(data_out), 128'(8'h00));
        check("rst_valid", 128'(port_in_valid), 128'(1'b0));

        // Status frame
        send(1'b1, 8'd0);
        send(1'b0, 8'h00); check("st1", 128'(data_out), 128'(8'h5C));
        send(1'b0, 8'h00); check("st2", 128'(data_out), 128'(8'h42));
        send(1'b0, 8'h00); check("st3", 128'(data_out), 128'(8'h01));
        send(1'b0, 8'h00); check("st4", 128'(data_out), 128'(8'h10));
        send(1'b0, 8'h00); check("st5", 128'(data_out), 128'(8'h10));

        send(1'b1, 8'd6); send(1'b0, 8'h00); check("coldboot1", 128'(data_out), 128'(8'h01));
        send(1'b1, 8'd6); send(1'b0, 8'h00); check("coldboot0", 128'(data_out), 128'(8'h00));

        // Clear the reset-time system interrupt
        send(1'b1, 8'd5); send(1'b0, 8'h01);
        check("ack_reply", 128'(data_out), 128'(8'h01));
        check("ack_pulse", 128'(int_ack), 128'(8'h01));
        tick();
        check("int_released", 128'(int_out_n), 128'(1'b1));

        // Burst variable write and read back
        send(1'b1, 8'd4); send(1'b0, 8'h42);
        send(1'b0, 8'h11); check("wr_strobe1", 128'(cfg_strobe), 128'(16'h0002));
        send(1'b0, 8'h22); check("wr_strobe2", 128'(cfg_strobe), 128'(16'h0004));
        send(1'b0, 8'h33); check("wr_strobe3", 128'(cfg_strobe), 128'(16'h0008));
        check("wr_vars", 128'(cfg_vars), 128'(128'h3322_1100));
        send(1'b1, 8'd9);
        send(1'b0, 8'h42); check("rd1", 128'(data_out), 128'(8'h11));
        send(1'b0, 8'h00); check("rd2", 128'(data_out), 128'(8'h22));
        send(1'b0, 8'h00); check("rd3", 128'(data_out), 128'(8'h33));

        // Ids out of range
        send(1'b1, 8'd4); send(1'b0, 8'h40);
        send(1'b0, 8'hAA); check("below_strobe", 128'(cfg_strobe), 128'(16'h0));
        send(1'b0, 8'hBB); check("below_strobe2", 128'(cfg_strobe), 128'(16'h0));
        send(1'b1, 8'd4); send(1'b0, BASE + 8'(NV));
        send(1'b0, 8'hCC); check("above_strobe", 128'(cfg_strobe), 128'(16'h0));
        check("oor_vars", 128'(cfg_vars), 128'(128'h3322_1100));
        send(1'b1, 8'd9); send(1'b0, BASE + 8'(NV)); check("rd_above", 128'(data_out), 128'(8'h00));
        send(1'b1, 8'd9); send(1'b0, 8'h40); check("rd_below", 128'(data_out), 128'(8'h00));

        // FIFO overflow with the consumer stalled
        send(1'b1, 8'd8);
        for (int i = 0; i < 9; i++) send(1'b0, 8'hA0 + 8'(i));
        check("ovf_int", 128'(int_out_n), 128'(1'b0));
        send(1'b1, 8'd6); send(1'b0, 8'h00); check("stat_ovf", 128'(data_out), 128'(8'h0C));
        send(1'b1, 8'd10); send(1'b0, 8'h00); check("free0", 128'(data_out), 128'(8'h00));
        send(1'b0, 8'h00);
        send(1'b1, 8'd6); send(1'b0, 8'h00); check("stat_clr", 128'(data_out), 128'(8'h04));
        send(1'b1, 8'd5); send(1'b0, 8'h01); tick();
        port_in_ready = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && got < 8; n++) begin
            if (port_in_valid) begin
                check("drain", 128'(port_in_data), 128'(8'hA0 + 8'(got)));
                got++;
            end
            tick();
        end
        check("drain_count", 128'(got), 128'(8));

        // Core-to-MCU byte
        port_out_data = 8'h5A; port_out_available = 1'b1;
        tick();
        check("poa_int", 128'(int_out_n), 128'(1'b0));
        send(1'b1, 8'd7);
        send(1'b0, 8'h00);
        check("po_avail", 128'(data_out), 128'(8'h01));
        check("po_strobe", 128'(port_out_strobe), 128'(1'b1));
        port_out_available = 1'b0;
        send(1'b0, 8'h00); check("po_data", 128'(data_out), 128'(8'h5A));
        send(1'b1, 8'd5); send(1'b0, 8'h01); tick();
        check("poa_release", 128'(int_out_n), 128'(1'b1));

        // LEDs, colour, buttons
        send(1'b1, 8'd2); send(1'b0, 8'h01); send(1'b0, 8'h02); send(1'b0, 8'h03);
        check("color", 128'(color), 128'(24'hC08040));
        send(1'b1, 8'd1); send(1'b0, 8'h02); check("leds", 128'(leds), 128'(2'b10));
        buttons = 2'b11;
        send(1'b1, 8'd3); send(1'b0, 8'h00); check("buttons", 128'(data_out), 128'(8'h03));

        // Reset in the middle of a burst
        send(1'b1, 8'd4); send(1'b0, 8'h41); send(1'b0, 8'h77);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_vars", 128'(cfg_vars), 128'(0));
        check("midrst_int", 128'(int_out_n), 128'(1'b0));
        @(negedge clk);
        tick();
        reset_n = 1'b1;
        tick();
        send(1'b0, 8'h99);
        check("stray_vars", 128'(cfg_vars), 128'(0));
        check("stray_strobe", 128'(cfg_strobe), 128'(0));

        // Random frames
        for (int f = 0; f < 400; f++) begin
            randomize_bg();
            if ($urandom_range(0, 9) == 0) send(1'b0, 8'($urandom));
            c = $urandom_range(0, 11);
            len = $urandom_range(0, 7);
            send(1'b1, 8'(c));
            for (int b = 0; b < len; b++) begin
                randomize_bg();
                d = 8'($urandom);
                if (b == 0 && (c == 4 || c == 9)) d = 8'($urandom_range(8'h3C, 8'h56));
                send(1'b0, d);
                repeat ($urandom_range(0, 2)) begin
                    randomize_bg();
                    tick();
                end
            end
            if ($urandom_range(0, 60) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
